word_unit_wide: RTL
===================

# word_unit_wide

Parametrised word-processing unit for a PLC core: two WIDTH-bit working registers A and B, a PUSH/POP operand stack, and an ALU with registered comparator and overflow flags. It sits between the core's instruction decoder and its data sources (program-memory immediate, RAM, register file). It adds a start/busy/done handshake so that multi-cycle operations, such as the iterative multiplier, can stall the decoder.

## Interface
Parameters:
- WIDTH, 16: data-path width in bits, ≥ 4.
- STACK_DEPTH, 4: operand-stack entries, ≥ 2, power of two.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- CPU_Reset  in  1  asynchronous, active-high reset.
- A_WE  in  1  load A.
- A_OPCode  in  2  A source select: 00 ArgToSet, 01 RAMData, 10 Register, 11 B.
- B_WE  in  1  load B.
- B_OPCode  in  2  B source select: 00 ArgToSet, 01 RAMData, 10 Register, 11 A.
- ArgToSet / RAMData / Register  in  WIDTH each  data sources.
- PUSH  in  1  push A onto the stack.
- POP  in  1  pop the stack top into B.
- ALU_Start  in  1  launch the operation in ALU_OPCode.
- ALU_OPCode  in  4  operation code.
- COMPARATORREG_EN  in  1  allow a compare op to update ComparatorResult.
- OV_EN  in  1  allow this operation to update OV.
- A  out  WIDTH  accumulator value.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle completion pulse.
- OV  out  1  overflow / carry flag.
- ComparatorResult  out  1  last compare result.
- StackFull  out  1  stack is full.
- StackEmpty  out  1  stack is empty.
- StackErr  out  1  sticky stack misuse flag.

## Operation
- Reset values: A, B, all stack entries and the stack pointer are 0; OV=0, ComparatorResult=0, Busy=0, Done=0, StackErr=0, StackFull=0, StackEmpty=1.
- State machine states:
  - IDLE accepts ALU_Start.
  - MUL runs WIDTH iterations, then returns to IDLE.
  - All other operations complete in IDLE.
- Opcodes:
  - 0 ADD: A←A+B.
  - 1 SUB: A←A−B.
  - 2 AND, 3 OR, 4 XOR: A←A op B.
  - 5 NOT: A←~A.
  - 6 SHL: A←A<<1.
  - 7 SHR: A←A>>1, logical.
  - 8 MUL: A←low WIDTH bits of A×B, unsigned.
  - 9 CMP_EQ: A==B.
  - 10 CMP_GT: A>B, unsigned.
  - 11 CMP_LT: A<B, unsigned.
  - 12 PASSB: A←B.
  - 13–15 NOP.
- Compare opcodes and NOP leave A unchanged. Every opcode produces Done.
- OV and OV_EN:
  - OV_EN is sampled with ALU_Start. If it is 0, OV holds its value.
  - ADD sets OV to the carry-out; SUB sets it to the borrow.
  - SHL and SHR set OV to the bit shifted out.
  - MUL sets OV=1 when the high half of the product is nonzero.
  - Logic ops and PASSB clear OV. Compares and NOP leave OV unchanged.
- ComparatorResult is written by compare opcodes only, and only when COMPARATORREG_EN is sampled 1 with ALU_Start.
- All operands are the pre-edge values of A and B. Width is always WIDTH; carries outside WIDTH are dropped.
- Priority in IDLE when several inputs are set in the same cycle:
  - ALU_Start beats A_WE, so that A_WE is ignored.
  - POP beats B_WE, so that B_WE is ignored.
  - PUSH+POP together: both are ignored, with no error.
  - A loads from B (A_OPCode=11) and B loads from A (B_OPCode=11) together: the two registers swap.
- Stack errors set StackErr, which stays set until reset:
  - PUSH while StackFull: ignored.
  - POP while StackEmpty: B unchanged.
- While Busy=1, the bench-visible inputs A_WE, B_WE, PUSH, POP and ALU_Start are ignored and never set StackErr.

## Timing
- Single-cycle operations:
  - ALU_Start is sampled at edge k; A, OV and ComparatorResult update at edge k.
  - Done=1 for the cycle after edge k. Busy stays 0.
- MUL:
  - ALU_Start is sampled at edge k, and Busy=1 from edge k.
  - A shift-add iteration runs at each of edges k+1…k+WIDTH.
  - A and OV update at edge k+WIDTH, which also clears Busy.
  - Done=1 for the cycle after edge k+WIDTH. Total latency is WIDTH+1 cycles to Done.
- Back-to-back: ALU_Start is accepted in the same cycle that Done is high.
- PUSH, POP, A_WE and B_WE take effect at the sampling edge. StackFull and StackEmpty are registered and reflect the new pointer after that same edge.
- CPU_Reset asserted mid-MUL aborts the multiply immediately and forces every output to its reset value. There is no Done pulse for the aborted operation.

## Configuration
- WORD_UNIT_MUL_EN defined: the MUL state and iterative multiplier are compiled in, as described above.
- WORD_UNIT_MUL_EN undefined: opcode 8 executes as NOP (single cycle, Done pulsed, A and OV unchanged), and Busy is tied to 0.

## Test plan
- Reset, then load A=0x00FF and B=0xFF01, ADD with OV_EN=1 → A=0x0000, OV=1, Done one cycle later.
- MUL, WIDTH=16, A=0x0100, B=0x0100, OV_EN=1 → Busy for 16 cycles, then A=0x0000, OV=1, Done at cycle 17. Inputs pulsed while Busy have no effect.
- CMP_GT with A=5, B=3: COMPARATORREG_EN=1 → ComparatorResult=1. Then CMP_LT with COMPARATORREG_EN=0 → ComparatorResult stays 1. A unchanged in both.
- PUSH A=1..4 → StackFull=1. A fifth PUSH → StackErr=1, stack unchanged. Four POPs → B=4,3,2,1, StackEmpty=1. An extra POP → B stays 1.
- Swap (A_OPCode=11 and B_OPCode=11, both WE) with A=0xAAAA, B=0x5555 → A=0x5555, B=0xAAAA.
- CPU_Reset asserted at iteration 8 of a MUL → all outputs reset immediately, no Done. A following ADD works normally.

Source files
------------

// File: rtl/word_unit_wide.sv
// Word-processing unit: A/B working registers, PUSH/POP operand stack and ALU with OV/compare flags.
// Define WORD_UNIT_MUL_EN to compile in the iterative multiplier (MUL state); otherwise opcode 8 is a NOP.
module word_unit_wide #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             CPU_Reset,
  input  logic             A_WE,
  input  logic [1:0]       A_OPCode,
  input  logic             B_WE,
  input  logic [1:0]       B_OPCode,
  input  logic [WIDTH-1:0] ArgToSet,
  input  logic [WIDTH-1:0] RAMData,
  input  logic [WIDTH-1:0] Register,
  input  logic             PUSH,
  input  logic             POP,
  input  logic             ALU_Start,
  input  logic [3:0]       ALU_OPCode,
  input  logic             COMPARATORREG_EN,
  input  logic             OV_EN,
  output logic [WIDTH-1:0] A,
  output logic             Busy,
  output logic             Done,
  output logic             OV,
  output logic             ComparatorResult,
  output logic             StackFull,
  output logic             StackEmpty,
  output logic             StackErr
);

  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = $clog2(STACK_DEPTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]  sp, sp_inc, sp_dec;

  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] alu_res, a_src, b_src;
  logic             alu_ov, wr_a, wr_ov, is_cmp, cmp_res, mul_start;
  logic             push_req, pop_req;

`ifdef WORD_UNIT_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mul_acc, mul_mcand, mul_acc_next;
  logic [WIDTH-1:0]   mul_mplier;
  logic [CNT_W-1:0]   mul_cnt;
  logic               mul_ov_en, mul_last;

  assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_last     = (mul_cnt == CNT_W'(WIDTH - 1));
  assign Busy         = (state == S_MUL);
`else
  assign Busy = 1'b0;
`endif

  assign sum_ext  = {1'b0, A} + {1'b0, b_reg};
  assign diff_ext = {1'b0, A} - {1'b0, b_reg};
  assign sp_inc   = sp + SP_W'(1);
  assign sp_dec   = sp - SP_W'(1);
  assign push_req = PUSH && !POP;
  assign pop_req  = POP && !PUSH;

  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) state <= S_IDLE;
    else           state <= state_next;
  end

  // Opcode decode; the top bit of the subtract result is the borrow.
  always_comb begin
    state_next = state;
    alu_res    = A;
    alu_ov     = OV;
    wr_a       = 1'b0;
    wr_ov      = 1'b0;
    is_cmp     = 1'b0;
    cmp_res    = 1'b0;
    mul_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ALU_Start) begin
          case (ALU_OPCode)
            4'd0:  begin alu_res = sum_ext[WIDTH-1:0];  alu_ov = sum_ext[WIDTH];  wr_a = 1'b1; wr_ov = OV_EN; end
            4'd1:  begin alu_res = diff_ext[WIDTH-1:0]; alu_ov = diff_ext[WIDTH]; wr_a = 1'b1; wr_ov = OV_EN; end
            4'd2:  begin alu_res = A & b_reg; alu_ov = 1'b0; wr_a = 1'b1; wr_ov = OV_EN; end
            4'd3:  begin alu_res = A | b_reg; alu_ov = 1'b0; wr_a = 1'b1; wr_ov = OV_EN; end
            4'd4:  begin alu_res = A ^ b_reg; alu_ov = 1'b0; wr_a = 1'b1; wr_ov = OV_EN; end
            4'd5:  begin alu_res = ~A;        alu_ov = 1'b0; wr_a = 1'b1; wr_ov = OV_EN; end
            4'd6:  begin alu_res = {A[WIDTH-2:0], 1'b0}; alu_ov = A[WIDTH-1]; wr_a = 1'b1; wr_ov = OV_EN; end
            4'd7:  begin alu_res = {1'b0, A[WIDTH-1:1]}; alu_ov = A[0];       wr_a = 1'b1; wr_ov = OV_EN; end
`ifdef WORD_UNIT_MUL_EN
            4'd8:  begin mul_start = 1'b1; state_next = S_MUL; end
`endif
            4'd9:  begin is_cmp = 1'b1; cmp_res = (A == b_reg); end
            4'd10: begin is_cmp = 1'b1; cmp_res = (A > b_reg);  end
            4'd11: begin is_cmp = 1'b1; cmp_res = (A < b_reg);  end
            4'd12: begin alu_res = b_reg; alu_ov = 1'b0; wr_a = 1'b1; wr_ov = OV_EN; end
            default: ;
          endcase
        end
      end
      S_MUL: begin
`ifdef WORD_UNIT_MUL_EN
        if (mul_last) state_next = S_IDLE;
`else
        state_next = S_IDLE;
`endif
      end
    endcase
  end

  always_comb begin
    case (A_OPCode)
      2'd0:    a_src = ArgToSet;
      2'd1:    a_src = RAMData;
      2'd2:    a_src = Register;
      default: a_src = b_reg;
    endcase
    case (B_OPCode)
      2'd0:    b_src = ArgToSet;
      2'd1:    b_src = RAMData;
      2'd2:    b_src = Register;
      default: b_src = A;
    endcase
  end

  // Register/stack datapath; every IDLE input is ignored while a multiply runs.
  always_ff @(posedge CLK or posedge CPU_Reset) begin
    if (CPU_Reset) begin
      A                <= '0;
      b_reg            <= '0;
      sp               <= '0;
      OV               <= 1'b0;
      ComparatorResult <= 1'b0;
      Done             <= 1'b0;
      StackFull        <= 1'b0;
      StackEmpty       <= 1'b1;
      StackErr         <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
`ifdef WORD_UNIT_MUL_EN
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
      mul_ov_en  <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      if (state == S_IDLE) begin
        if (ALU_Start) begin
          Done <= !mul_start;
          if (wr_a)  A  <= alu_res;
          if (wr_ov) OV <= alu_ov;
          if (is_cmp && COMPARATORREG_EN) ComparatorResult <= cmp_res;
`ifdef WORD_UNIT_MUL_EN
          if (mul_start) begin
            mul_acc    <= '0;
            mul_mcand  <= {{WIDTH{1'b0}}, A};
            mul_mplier <= b_reg;
            mul_cnt    <= '0;
            mul_ov_en  <= OV_EN;
          end
`endif
        end else if (A_WE) begin
          A <= a_src;
        end

        if (pop_req) begin
          if (StackEmpty) begin
            StackErr <= 1'b1;
          end else begin
            b_reg      <= stack_mem[sp_dec[IDX_W-1:0]];
            sp         <= sp_dec;
            StackEmpty <= (sp_dec == '0);
            StackFull  <= 1'b0;
          end
        end else if (push_req) begin
          if (StackFull) begin
            StackErr <= 1'b1;
          end else begin
            stack_mem[sp[IDX_W-1:0]] <= A;
            sp         <= sp_inc;
            StackFull  <= (sp_inc == SP_W'(STACK_DEPTH));
            StackEmpty <= 1'b0;
          end
        end

        if (!POP && B_WE) b_reg <= b_src;
      end
`ifdef WORD_UNIT_MUL_EN
      else begin
        mul_acc    <= mul_acc_next;
        mul_mcand  <= {mul_mcand[2*WIDTH-2:0], 1'b0};
        mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
        mul_cnt    <= mul_cnt + CNT_W'(1);
        if (mul_last) begin
          A    <= mul_acc_next[WIDTH-1:0];
          Done <= 1'b1;
          if (mul_ov_en) OV <= |mul_acc_next[2*WIDTH-1:WIDTH];
        end
      end
`endif
    end
  end

endmodule
